// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: maps 32-bit word loads/stores onto a 16-bit async SRAM as two half-word phases.
// ready stays low while an access is in flight so the pipeline freezes around it.
module mem_stage_sram_ctrl #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned WCW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDXW = SRAM_AW - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state, state_nxt;
    logic [WCW-1:0]     wcnt, wcnt_nxt;
    logic               op_wr, op_wr_nxt;
    logic               req_c;
    logic               last_c;
    logic [IDXW-1:0]    word_idx_c;
    logic [SRAM_AW-1:0] addr_nxt;
    logic [15:0]        dq_nxt;
    logic               oe_nxt;
    logic               we_n_nxt;
    logic               cap_lo_c;
    logic               cap_hi_c;

    assign req_c      = wr_en | rd_en;
    assign last_c     = (wcnt == WCW'(WAIT_CYCLES));
    assign word_idx_c = IDXW'((address - 32'(BASE_ADDR)) >> 2);
    assign ready      = ((state == IDLE) && !req_c) || (state == DONE);
    assign cap_lo_c   = (state == LOW)  && last_c && !op_wr;
    assign cap_hi_c   = (state == HIGH) && last_c && !op_wr;

    // Next state plus the SRAM pin values for the upcoming cycle, so pins come straight off flops
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        op_wr_nxt = op_wr;
        addr_nxt  = '0;
        dq_nxt    = '0;
        oe_nxt    = 1'b0;
        we_n_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (req_c) begin
                    state_nxt = LOW;
                    wcnt_nxt  = '0;
                    op_wr_nxt = wr_en;
                end
            end
            LOW: begin
                if (last_c) begin
                    state_nxt = HIGH;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCW'(1);
                end
            end
            HIGH: begin
                if (last_c) begin
                    state_nxt = DONE;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state_nxt == LOW) || (state_nxt == HIGH)) begin
            addr_nxt = {word_idx_c, (state_nxt == HIGH)};
            oe_nxt   = op_wr_nxt;
            we_n_nxt = !op_wr_nxt;
            if (op_wr_nxt) begin
                dq_nxt = (state_nxt == HIGH) ? write_data[31:16] : write_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            op_wr       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            op_wr       <= op_wr_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dq_nxt;
            sram_dq_oe  <= oe_nxt;
            sram_we_n   <= we_n_nxt;
        end
    end

    // Load data captured from the SRAM on the last cycle of each read phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else begin
            if (cap_lo_c) read_data[15:0]  <= sram_dq_in;
            if (cap_hi_c) read_data[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: WAIT_CYCLES=1 instance checked every cycle against a timeline model,
// WAIT_CYCLES=0 instance checked with directed literals.
module tb_mem_stage_sram_ctrl;

    localparam int AW = 7;
    localparam int W1 = 1;
    localparam int L1 = 2 * W1 + 3;

    logic clk, rst;
    int   n_checks, n_errors;

    // WAIT_CYCLES=1 instance signals
    logic          wr1, rd1;
    logic [31:0]   addr1, wdata1, rdata1;
    logic          rdy1, oe1, we_n1;
    logic [AW-1:0] saddr1;
    logic [15:0]   dq_out1, dq_in1;
    // WAIT_CYCLES=0 instance signals
    logic          wr0, rd0;
    logic [31:0]   addr0, wdata0, rdata0;
    logic          rdy0, oe0, we_n0;
    logic [AW-1:0] saddr0;
    logic [15:0]   dq_out0, dq_in0;

    logic [15:0] sram1 [0:127];
    logic [15:0] sram0 [0:127];
    logic [15:0] ref_mem [0:127];

    mem_stage_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(W1), .BASE_ADDR(1024)) u_w1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wdata1), .read_data(rdata1), .ready(rdy1), .sram_addr(saddr1),
        .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
    );

    mem_stage_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(0), .BASE_ADDR(1024)) u_w0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
        .write_data(wdata0), .read_data(rdata0), .ready(rdy0), .sram_addr(saddr0),
        .sram_dq_out(dq_out0), .sram_dq_in(dq_in0), .sram_dq_oe(oe0), .sram_we_n(we_n0)
    );

    always #5 clk = ~clk;

    // Async SRAM models: combinational read, write while strobed
    assign dq_in1 = sram1[saddr1];
    assign dq_in0 = sram0[saddr0];
    always @(posedge clk) if (oe1 && !we_n1) sram1[saddr1] <= dq_out1;
    always @(posedge clk) if (oe0 && !we_n0) sram0[saddr0] <= dq_out0;

    // Reference model: an access is a timeline of cycles k=0..L1 after the request is seen
    int          mk;
    logic        m_wr;
    logic [5:0]  m_word;
    logic [31:0] m_wdata, m_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mk   <= -1;
            m_rd <= '0;
        end else if (mk < 0) begin
            if (wr1 || rd1) begin
                mk      <= 1;
                m_wr    <= wr1;
                m_word  <= 6'((addr1 - 32'd1024) >> 2);
                m_wdata <= wdata1;
            end
        end else if (mk == L1) begin
            mk <= -1;
        end else begin
            if (mk == W1 + 1) begin
                if (m_wr) ref_mem[{m_word, 1'b0}] <= m_wdata[15:0];
                else      m_rd[15:0] <= ref_mem[{m_word, 1'b0}];
            end
            if (mk == L1 - 1) begin
                if (m_wr) ref_mem[{m_word, 1'b1}] <= m_wdata[31:16];
                else      m_rd[31:16] <= ref_mem[{m_word, 1'b1}];
            end
            mk <= mk + 1;
        end
    end

    logic          e_ready, e_lo, e_hi, e_oe, e_we_n;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_dq;

    always_comb begin
        e_lo    = (mk >= 1) && (mk <= W1 + 1);
        e_hi    = (mk >= W1 + 2) && (mk <= L1 - 1);
        e_ready = (mk < 0) ? !(wr1 || rd1) : (mk == L1);
        e_oe    = (e_lo || e_hi) && m_wr;
        e_we_n  = !e_oe;
        e_addr  = e_lo ? {m_word, 1'b0} : (e_hi ? {m_word, 1'b1} : '0);
        e_dq    = !m_wr ? 16'h0 : (e_lo ? m_wdata[15:0] : (e_hi ? m_wdata[31:16] : 16'h0));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("ready", 32'(rdy1), 32'(e_ready));
            chk("read_data", rdata1, m_rd);
            chk("we_n", 32'(we_n1), 32'(e_we_n));
            chk("dq_oe", 32'(oe1), 32'(e_oe));
            chk("sram_addr", 32'(saddr1), 32'(e_addr));
            chk("dq_out", 32'(dq_out1), 32'(e_dq));
        end
    end

    // Present a request at #1 after an edge, count stall cycles, release after the DONE edge
    task automatic do_access(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, output int stalls);
        if (sel) begin wr1 = wr; rd1 = rd; addr1 = a; wdata1 = d; end
        else     begin wr0 = wr; rd0 = rd; addr0 = a; wdata0 = d; end
        stalls = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (sel ? rdy1 : rdy0) break;
            stalls++;
        end
        @(posedge clk);
        #1;
        wr1 = 0; rd1 = 0; wr0 = 0; rd0 = 0;
    endtask

    int s;

    initial begin
        n_checks = 0; n_errors = 0;
        clk = 0; rst = 0;
        wr1 = 0; rd1 = 0; addr1 = 0; wdata1 = 0;
        wr0 = 0; rd0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy1), 32'd1);
        chk("rst_read_data", rdata1, 32'd0);
        chk("rst_we_n", 32'(we_n1), 32'd1);

        do_access(1, 1, 0, 32'd1032, 32'hDEADBEEF, s);
        chk("wr_stalls", 32'(s), 32'd5);
        chk("sram4", 32'(sram1[4]), 32'h0000BEEF);
        chk("sram5", 32'(sram1[5]), 32'h0000DEAD);

        do_access(1, 0, 1, 32'd1032, 32'h0, s);
        chk("rd_stalls", 32'(s), 32'd5);
        chk("rd_data", rdata1, 32'hDEADBEEF);

        do_access(1, 1, 0, 32'd1024, 32'h1, s);
        chk("b2b_wr_stalls", 32'(s), 32'd5);
        do_access(1, 0, 1, 32'd1024, 32'h0, s);
        chk("b2b_rd_stalls", 32'(s), 32'd5);
        chk("b2b_rd_data", rdata1, 32'h1);

        // Reset during the first HIGH cycle of a write
        wr1 = 1; addr1 = 32'd1024; wdata1 = 32'hCAFE5A5A;
        repeat (3) @(posedge clk);
        #2 rst = 0; wr1 = 0;
        #1;
        chk("arst_we_n", 32'(we_n1), 32'd1);
        chk("arst_oe", 32'(oe1), 32'd0);
        chk("arst_addr", 32'(saddr1), 32'd0);
        chk("arst_dq", 32'(dq_out1), 32'd0);
        chk("arst_rd", rdata1, 32'd0);
        chk("arst_ready", 32'(rdy1), 32'd1);
        @(posedge clk);
        #1 rst = 1;
        chk("arst_sram0", 32'(sram1[0]), 32'h00005A5A);
        chk("arst_sram1", 32'(sram1[1]), 32'h00000000);
        do_access(1, 0, 1, 32'd1024, 32'h0, s);
        chk("post_rst_stalls", 32'(s), 32'd5);
        chk("post_rst_rd", rdata1, 32'h00005A5A);

        // Zero wait cycles, both enables set: handled as a write
        do_access(0, 1, 1, 32'd1028, 32'h12345678, s);
        chk("w0_stalls", 32'(s), 32'd3);
        chk("w0_sram2", 32'(sram0[2]), 32'h00005678);
        chk("w0_sram3", 32'(sram0[3]), 32'h00001234);
        chk("w0_rd_unchanged", rdata0, 32'd0);
        do_access(0, 0, 1, 32'd1028, 32'h0, s);
        chk("w0_rd_stalls", 32'(s), 32'd3);
        chk("w0_rd_data", rdata0, 32'h12345678);

        foreach (ref_mem[i]) begin
            if (i == 0 || i == 1 || i == 4 || i == 5)
                chk("mem_vs_model", 32'(sram1[i]), 32'(ref_mem[i]));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
